sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. Supports up to DIGITS BCD digits, each with a decimal point. A load strobe captures the digits into a shadow register, which is committed to the display only at a frame boundary, so the display never tears. The block sits between application logic (counters, sensor readouts) and the board's segment/anode pins, and supersedes single-digit static drive.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8); digit 0 is least significant.
REFRESH_DIV, 50000, clk cycles each digit is lit (>=2).
BLANK_CYCLES, 4, clk cycles all anodes are off between digits, for ghost suppression (>=1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load_i  input  1  single-cycle strobe; captures digits_i and dp_i into the shadow register
digits_i  input  4*DIGITS  BCD nibbles; digit k is bits [4k+3:4k]
dp_i  input  DIGITS  decimal point request per digit, 1 = on
lzb_en_i  input  1  leading-zero blanking enable, sampled every cycle
seg_o  output  7  {a,b,c,d,e,f,g}, active-low
dp_o  output  1  decimal point segment, active-low
an_o  output  DIGITS  digit anode enables, active-low, at most one low
pending_o  output  1  shadow register holds data not yet committed
frame_o  output  1  one-cycle pulse when the digit index wraps from DIGITS-1 to 0

Behaviour:
- Reset (async assert, sync release) values: seg_o=7'b1111111, dp_o=1, an_o all 1, pending_o=0, frame_o=0, digit index=0, FSM=BLANK with counter 0, display register all nibbles 4'hF (blank) and dp all 0, shadow register cleared to the same values.
- FSM has two states, BLANK and SHOW, with one down-counter.
- BLANK: an_o all 1 and seg_o all 1 for BLANK_CYCLES cycles, then go to SHOW with counter REFRESH_DIV.
- SHOW: an_o[idx]=0 and seg_o/dp_o are driven from the display register for REFRESH_DIV cycles, then go to BLANK.
- idx increments on each SHOW->BLANK transition and wraps from DIGITS-1 to 0.
- On the wrap, frame_o pulses for that cycle. If pending_o=1, the shadow register is copied to the display register in the same cycle and pending_o clears.
- Decode, registered so that seg_o changes on the same edge as an_o:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 = 1111111 (digit dark); dp_o still follows dp bit.
- Leading-zero blanking, when lzb_en_i=1: digit k (k>0) is dark if it and every digit above it are 0. Digit 0 is never blanked. dp still shows on a blanked digit if its dp bit is set.
- load_i:
  - Shadow register captures inputs on the edge and pending_o=1 on the next cycle.
  - A load while pending overwrites the shadow; the last value wins.
  - Load in the same cycle as a frame commit: the old shadow is committed, the new data goes to the shadow, and pending_o stays 1.
- Full frame period = DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Worst-case load-to-display latency is one frame plus one cycle.
- Reset mid-frame immediately forces the reset values. The display stays blank until a load is committed.
- Invariant: an_o is never low for more than one digit, and never low during BLANK.

Test Plan:
Shared settings: DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset then idle 30 cycles -> an_o cycles 1110, 1101, 1011, 0111 (each 4 cycles, 1 cycle 1111 between); seg_o=1111111 throughout; frame_o pulses every 20 cycles.
2. load_i with digits_i=16'h1234, dp_i=4'b0010 -> pending_o=1; at next frame_o, commit and pending_o=0. While an_o=1110, seg_o=1001100 (4). While an_o=1101, seg_o=0000110 (3) and dp_o=0.
3. digits_i=16'h0070, lzb_en_i=1 -> digits 3 and 2 dark, digit 1 shows 0001111, digit 0 shows 0000001. With lzb_en_i=0, digits 3 and 2 show 0000001.
4. digits_i=16'hA9FB -> digits 3, 1 and 0 show 1111111; digit 2 shows 0000100.
5. Two loads (16'h1111 then 16'h2222) within one frame, and a third load coincident with frame_o -> 2222 is displayed; the third value stays pending until the next frame.
6. rst_n pulsed low mid-SHOW -> outputs return to reset values asynchronously; after release, the display is blank until a load is committed.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// A shadow register takes loads at any time and reaches the display only at a frame boundary.
module sevenseg_scan_ctrl #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   digits_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  lzb_en_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  pending_o,
   output logic                  frame_o
);

   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [6:0]  SEG_OFF = 7'b1111111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         disp_nib [DIGITS];
   logic [DIGITS-1:0]  disp_dp;
   logic [3:0]         shd_nib  [DIGITS];
   logic [DIGITS-1:0]  shd_dp;

   logic [DIGITS-1:0]  lzb_dark;
   logic               zero_run;
   logic [6:0]         seg_next;
   logic               dp_next;
   logic               idx_wrap;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      zero_run = 1'b1;
      lzb_dark = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         zero_run    = zero_run & (disp_nib[k] == 4'h0);
         lzb_dark[k] = (k != 0) && zero_run;
      end
   end

   always_comb begin
      seg_next = (lzb_en_i && lzb_dark[idx]) ? SEG_OFF : bcd_to_seg(disp_nib[idx]);
      dp_next  = ~disp_dp[idx];
      idx_wrap = (idx == IDX_W'(DIGITS - 1));
   end

   // Scan FSM; outputs are registered on the same edge as the state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_BLANK;
         cnt       <= '0;
         idx       <= '0;
         seg_o     <= SEG_OFF;
         dp_o      <= 1'b1;
         an_o      <= '1;
         pending_o <= 1'b0;
         frame_o   <= 1'b0;
         disp_dp   <= '0;
         shd_dp    <= '0;
         for (int k = 0; k < int'(DIGITS); k++) begin
            disp_nib[k] <= 4'hF;
            shd_nib[k]  <= 4'hF;
         end
      end else begin
         frame_o <= 1'b0;

         if (load_i) begin
            shd_dp    <= dp_i;
            pending_o <= 1'b1;
            for (int k = 0; k < int'(DIGITS); k++) begin
               shd_nib[k] <= digits_i[4*k +: 4];
            end
         end

         case (state)
            ST_BLANK: begin
               if (cnt == '0) begin
                  state <= ST_SHOW;
                  cnt   <= CNT_W'(REFRESH_DIV - 1);
                  an_o  <= ~(DIGITS'(1) << idx);
                  seg_o <= seg_next;
                  dp_o  <= dp_next;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (cnt == '0) begin
                  state <= ST_BLANK;
                  cnt   <= CNT_W'(BLANK_CYCLES - 1);
                  an_o  <= '1;
                  seg_o <= SEG_OFF;
                  dp_o  <= 1'b1;
                  idx   <= idx_wrap ? '0 : idx + IDX_W'(1);
                  if (idx_wrap) begin
                     frame_o <= 1'b1;
                     // Commit the old shadow; a load on this same edge stays pending.
                     if (pending_o) begin
                        disp_nib  <= shd_nib;
                        disp_dp   <= shd_dp;
                        pending_o <= load_i;
                     end
                  end
               end else begin
                  cnt   <= cnt - CNT_W'(1);
                  seg_o <= seg_next;
                  dp_o  <= dp_next;
               end
            end
            default: begin
               state <= ST_BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
// Frame phase ph counts cycles since reset release modulo 20; digit k is lit at phases 5k+1..5k+4.
module tb_sevenseg_scan_ctrl;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] DK = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_i;
   logic [15:0] digits_i;
   logic [3:0]  dp_i;
   logic        lzb_en_i;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        pending_o;
   logic        frame_o;

   int n_checks = 0;
   int n_errors = 0;
   int ph = 0;

   sevenseg_scan_ctrl #(
      .DIGITS       (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_i),
      .digits_i  (digits_i),
      .dp_i      (dp_i),
      .lzb_en_i  (lzb_en_i),
      .seg_o     (seg_o),
      .dp_o      (dp_o),
      .an_o      (an_o),
      .pending_o (pending_o),
      .frame_o   (frame_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (ph=%0d, t=%0t)", tag, got, exp, ph, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ph = (ph + 1) % 20;
   endtask

   task automatic goto(input int p);
      tick();
      while (ph != p) tick();
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
      load_i   = 1'b1;
      digits_i = d;
      dp_i     = dp;
      tick();
      load_i   = 1'b0;
   endtask

   // segs = {d3,d2,d1,d0}; dpn = expected active-low dp_o per digit
   task automatic check_digits(input string tag, input logic [27:0] segs, input logic [3:0] dpn);
      logic [3:0] an_exp;
      for (int k = 0; k < 4; k++) begin
         goto(5 * k + 2);
         an_exp = ~(4'b0001 << k);
         check({tag, "_an"}, 32'(an_o), 32'(an_exp));
         check({tag, "_seg"}, 32'(seg_o), 32'(segs[7*k +: 7]));
         check({tag, "_dp"}, 32'(dp_o), 32'(dpn[k]));
      end
   endtask

   initial begin
      logic [3:0] an_exp;
      int p;
      rst_n    = 1'b0;
      load_i   = 1'b0;
      digits_i = 16'h0000;
      dp_i     = 4'h0;
      lzb_en_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ph    = 0;

      check("rst_seg", 32'(seg_o), 32'(DK));
      check("rst_dp", 32'(dp_o), 32'h1);
      check("rst_pending", 32'(pending_o), 32'h0);

      // 1: idle scan after reset, blank display
      for (int c = 0; c < 30; c++) begin
         p = c % 20;
         an_exp = (p % 5 == 0) ? 4'hF : ~(4'b0001 << (p / 5));
         check("idle_an", 32'(an_o), 32'(an_exp));
         check("idle_seg", 32'(seg_o), 32'(DK));
         check("idle_frame", 32'(frame_o), 32'((c > 0 && p == 0) ? 1 : 0));
         tick();
      end

      // 2: load 1234 with dp on digit 1
      goto(3);
      do_load(16'h1234, 4'b0010);
      check("t2_pending_set", 32'(pending_o), 32'h1);
      goto(19);
      check("t2_pending_hold", 32'(pending_o), 32'h1);
      goto(0);
      check("t2_frame", 32'(frame_o), 32'h1);
      check("t2_pending_clr", 32'(pending_o), 32'h0);
      check_digits("t2", {S1, S2, S3, S4}, 4'b1101);

      // 3: 0070 with leading-zero blanking, then without
      lzb_en_i = 1'b1;
      goto(3);
      do_load(16'h0070, 4'b0000);
      goto(0);
      check("t3_frame", 32'(frame_o), 32'h1);
      check_digits("t3_lzb", {DK, DK, S7, S0}, 4'hF);
      lzb_en_i = 1'b0;
      goto(12);
      check("t3_nolzb_d2", 32'(seg_o), 32'(S0));
      goto(17);
      check("t3_nolzb_d3", 32'(seg_o), 32'(S0));

      // 4: non-BCD nibbles go dark; dp still shows on a dark digit
      lzb_en_i = 1'b1;
      goto(3);
      do_load(16'hA9FB, 4'b0001);
      goto(0);
      check_digits("t4", {DK, S9, DK, DK}, 4'b1110);

      // 5: last load in a frame wins; load on the commit edge stays pending
      lzb_en_i = 1'b0;
      goto(3);
      do_load(16'h1111, 4'b0000);
      goto(8);
      do_load(16'h2222, 4'b0000);
      goto(19);
      do_load(16'h3333, 4'b0000);
      check("t5_frame", 32'(frame_o), 32'h1);
      check("t5_pending_keep", 32'(pending_o), 32'h1);
      check_digits("t5_2222", {S2, S2, S2, S2}, 4'hF);
      goto(19);
      check("t5_pending_hold", 32'(pending_o), 32'h1);
      goto(0);
      check("t5_frame2", 32'(frame_o), 32'h1);
      check("t5_pending_clr", 32'(pending_o), 32'h0);
      check_digits("t5_3333", {S3, S3, S3, S3}, 4'hF);

      // 6: asynchronous reset mid-SHOW with a load pending
      goto(6);
      do_load(16'h4444, 4'b1111);
      check("t6_pre_an", 32'(an_o), 32'hD);
      check("t6_pre_pending", 32'(pending_o), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_an", 32'(an_o), 32'hF);
      check("t6_rst_seg", 32'(seg_o), 32'(DK));
      check("t6_rst_dp", 32'(dp_o), 32'h1);
      check("t6_rst_pending", 32'(pending_o), 32'h0);
      check("t6_rst_frame", 32'(frame_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ph    = 0;
      check_digits("t6_blank", {DK, DK, DK, DK}, 4'hF);
      goto(0);
      check("t6_frame", 32'(frame_o), 32'h1);
      check_digits("t6_blank2", {DK, DK, DK, DK}, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
